// File: rtl/snitch_icache_tag_lookup.sv
// Tag SRAM controller for the snitch icache: owns the single-port tag RAM and
// sequences init/flush sweeps, refill tag writes and tag lookups.
module snitch_icache_tag_lookup #(
    parameter int unsigned WAY_COUNT   = 4,
    parameter int unsigned TAG_WIDTH   = 20,
    parameter int unsigned LINE_COUNT  = 64,
    parameter int unsigned COUNT_ALIGN = 6,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_valid_i,
    output logic                               flush_ready_o,
    input  logic                               lookup_valid_i,
    output logic                               lookup_ready_o,
    input  logic [COUNT_ALIGN-1:0]             lookup_idx_i,
    input  logic [TAG_WIDTH-1:0]               lookup_tag_i,
    input  logic [ID_WIDTH-1:0]                lookup_id_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic                               rsp_hit_o,
    output logic [$clog2(WAY_COUNT)-1:0]       rsp_way_o,
    output logic                               rsp_error_o,
    output logic [ID_WIDTH-1:0]                rsp_id_o,
    input  logic                               write_valid_i,
    output logic                               write_ready_o,
    input  logic [COUNT_ALIGN-1:0]             write_idx_i,
    input  logic [$clog2(WAY_COUNT)-1:0]       write_way_i,
    input  logic [TAG_WIDTH-1:0]               write_tag_i,
    input  logic                               write_error_i,
    output logic                               sram_req_o,
    output logic                               sram_write_o,
    output logic [COUNT_ALIGN-1:0]             sram_addr_o,
    output logic [WAY_COUNT*(TAG_WIDTH+2)-1:0] sram_wdata_o,
    output logic [WAY_COUNT-1:0]               sram_be_o,
    input  logic [WAY_COUNT*(TAG_WIDTH+2)-1:0] sram_rdata_i
);

    localparam int unsigned ENTRY_W = TAG_WIDTH + 2;
    localparam int unsigned WAY_W   = $clog2(WAY_COUNT);
    localparam logic [COUNT_ALIGN-1:0] LAST_LINE = COUNT_ALIGN'(LINE_COUNT - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_RESP,
        ST_FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_ALIGN-1:0] count_q, count_d;
    logic                   flush_done_q, flush_done_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   lookup_accept;
    logic                   hit_d;
    logic [WAY_W-1:0]       way_d;
    logic                   err_d;

    assign rsp_valid_o = (state_q == ST_RESP);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        flush_done_d   = 1'b0;
        flush_ready_o  = 1'b0;
        write_ready_o  = 1'b0;
        lookup_ready_o = 1'b0;
        lookup_accept  = 1'b0;
        sram_req_o     = 1'b0;
        sram_write_o   = 1'b0;
        sram_addr_o    = '0;
        sram_wdata_o   = '0;
        sram_be_o      = '0;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                // Sweep strobes are qualified by rst_ni so outputs drop the moment reset asserts.
                sram_req_o   = rst_ni;
                sram_write_o = rst_ni;
                sram_addr_o  = count_q;
                sram_be_o    = {WAY_COUNT{rst_ni}};
                count_d      = count_q + COUNT_ALIGN'(1);
                if (count_q == LAST_LINE) begin
                    state_d      = ST_IDLE;
                    count_d      = '0;
                    flush_done_d = (state_q == ST_FLUSH);
                end
            end
            ST_IDLE: begin
                if (flush_done_q) begin
                    flush_ready_o = 1'b1;
                end else if (flush_valid_i) begin
                    state_d = ST_FLUSH;
                end else if (write_valid_i) begin
                    write_ready_o          = 1'b1;
                    sram_req_o             = 1'b1;
                    sram_write_o           = 1'b1;
                    sram_addr_o            = write_idx_i;
                    sram_wdata_o           = {WAY_COUNT{1'b1, write_error_i, write_tag_i}};
                    sram_be_o[write_way_i] = 1'b1;
                end else begin
                    lookup_ready_o = 1'b1;
                    if (lookup_valid_i) begin
                        lookup_accept = 1'b1;
                        sram_req_o    = 1'b1;
                        sram_addr_o   = lookup_idx_i;
                        state_d       = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Lowest matching way wins when several ways hold the same tag.
    always_comb begin
        hit_d = 1'b0;
        way_d = '0;
        err_d = 1'b0;
        for (int unsigned w = 0; w < WAY_COUNT; w++) begin
            if (!hit_d && sram_rdata_i[w*ENTRY_W + TAG_WIDTH + 1]
                    && (sram_rdata_i[w*ENTRY_W +: TAG_WIDTH] == tag_q)) begin
                hit_d = 1'b1;
                way_d = WAY_W'(w);
                err_d = sram_rdata_i[w*ENTRY_W + TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_INIT;
            count_q      <= '0;
            flush_done_q <= 1'b0;
            tag_q        <= '0;
            rsp_id_o     <= '0;
            rsp_hit_o    <= 1'b0;
            rsp_way_o    <= '0;
            rsp_error_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            flush_done_q <= flush_done_d;
            if (lookup_accept) begin
                tag_q    <= lookup_tag_i;
                rsp_id_o <= lookup_id_i;
            end
            if (state_q == ST_READ) begin
                rsp_hit_o   <= hit_d;
                rsp_way_o   <= way_d;
                rsp_error_o <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_snitch_icache_tag_lookup.sv
// Bench for snitch_icache_tag_lookup: behavioural tag SRAM plus a per-entry
// reference model of the cache contents, directed and randomized operations.
module tb_snitch_icache_tag_lookup;

    localparam int WAYS  = 4;
    localparam int TW    = 20;
    localparam int LINES = 64;
    localparam int IW    = 6;
    localparam int DW    = 4;
    localparam int EW    = TW + 2;
    localparam int MW    = WAYS * EW;
    localparam logic [TW-1:0] POOL = 20'hC0DE0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_valid, flush_ready;
    logic          lookup_valid, lookup_ready;
    logic [IW-1:0] lookup_idx;
    logic [TW-1:0] lookup_tag;
    logic [DW-1:0] lookup_id;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_error;
    logic [1:0]    rsp_way;
    logic [DW-1:0] rsp_id;
    logic          write_valid, write_ready, write_error;
    logic [IW-1:0] write_idx;
    logic [1:0]    write_way;
    logic [TW-1:0] write_tag;
    logic          sram_req, sram_write;
    logic [IW-1:0] sram_addr;
    logic [MW-1:0] sram_wdata, sram_rdata;
    logic [WAYS-1:0] sram_be;

    logic [MW-1:0] mem [LINES];
    logic          scramble;

    int checks = 0;
    int errors = 0;

    bit            m_valid [LINES][WAYS];
    bit            m_err   [LINES][WAYS];
    logic [TW-1:0] m_tag   [LINES][WAYS];

    always #5 clk = ~clk;

    snitch_icache_tag_lookup #(
        .WAY_COUNT  (WAYS),
        .TAG_WIDTH  (TW),
        .LINE_COUNT (LINES),
        .COUNT_ALIGN(IW),
        .ID_WIDTH   (DW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_valid_i (flush_valid),
        .flush_ready_o (flush_ready),
        .lookup_valid_i(lookup_valid),
        .lookup_ready_o(lookup_ready),
        .lookup_idx_i  (lookup_idx),
        .lookup_tag_i  (lookup_tag),
        .lookup_id_i   (lookup_id),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_hit_o     (rsp_hit),
        .rsp_way_o     (rsp_way),
        .rsp_error_o   (rsp_error),
        .rsp_id_o      (rsp_id),
        .write_valid_i (write_valid),
        .write_ready_o (write_ready),
        .write_idx_i   (write_idx),
        .write_way_i   (write_way),
        .write_tag_i   (write_tag),
        .write_error_i (write_error),
        .sram_req_o    (sram_req),
        .sram_write_o  (sram_write),
        .sram_addr_o   (sram_addr),
        .sram_wdata_o  (sram_wdata),
        .sram_be_o     (sram_be),
        .sram_rdata_i  (sram_rdata)
    );

    // Tag SRAM; scramble fills it with valid entries from the stimulus tag pool
    // so a skipped init/flush line shows up as a spurious hit.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < LINES; i++)
                for (int w = 0; w < WAYS; w++)
                    mem[i][w*EW +: EW] <= {1'b1, 1'($urandom_range(0, 1)), TW'(POOL + $urandom_range(0, 3))};
        end else if (sram_req) begin
            if (sram_write) begin
                for (int w = 0; w < WAYS; w++)
                    if (sram_be[w]) mem[sram_addr][w*EW +: EW] <= sram_wdata[w*EW +: EW];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[i][w] = 1'b0;
                m_err[i][w]   = 1'b0;
                m_tag[i][w]   = '0;
            end
    endtask

    task automatic predict(input int idx, input logic [TW-1:0] tag,
                           output bit hit, output int way, output bit err);
        hit = 1'b0; way = 0; err = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
                hit = 1'b1; way = w; err = m_err[idx][w];
            end
    endtask

    // Counts sweep lines from the current negedge until a ready appears;
    // optionally asserts reset when line abort_line is seen.
    task automatic sweep(input int abort_line, output int lines, output bit ok);
        bit done;
        lines = 0; ok = 1'b1; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (flush_ready || lookup_ready) begin
                done = 1'b1;
            end else begin
                if (sram_req) begin
                    if (!(sram_write && sram_addr == IW'(lines) && sram_wdata == '0 && sram_be == '1))
                        ok = 1'b0;
                    if (lines == abort_line) begin
                        rst_n = 1'b0;
                        done  = 1'b1;
                    end
                    lines++;
                end
                if (!done) @(negedge clk);
            end
        end
    endtask

    task automatic do_write(input int idx, input int way, input logic [TW-1:0] tag, input bit err);
        logic [MW-1:0]   exp_wd;
        logic [WAYS-1:0] exp_be;
        @(negedge clk);
        write_valid = 1'b1; write_idx = IW'(idx); write_way = 2'(way);
        write_tag = tag; write_error = err;
        exp_be = '0; exp_be[way] = 1'b1;
        for (int w = 0; w < WAYS; w++) exp_wd[w*EW +: EW] = {1'b1, err, tag};
        #1;
        check("wr_ready", {write_ready, lookup_ready, flush_ready}, 3'b100);
        check("wr_req", {sram_req, sram_write}, 2'b11);
        check("wr_addr", sram_addr, idx);
        check("wr_be", sram_be, exp_be);
        check("wr_wdata", sram_wdata, exp_wd);
        @(negedge clk);
        write_valid = 1'b0;
        m_valid[idx][way] = 1'b1; m_err[idx][way] = err; m_tag[idx][way] = tag;
    endtask

    task automatic do_lookup(input int idx, input logic [TW-1:0] tag, input int hold);
        bit eh, ee;
        int ew;
        logic [DW-1:0] id;
        predict(idx, tag, eh, ew, ee);
        id = DW'($urandom());
        @(negedge clk);
        lookup_valid = 1'b1; lookup_idx = IW'(idx); lookup_tag = tag; lookup_id = id; rsp_ready = 1'b0;
        #1;
        check("lk_ready", {lookup_ready, write_ready, flush_ready}, 3'b100);
        check("lk_req", {sram_req, sram_write}, 2'b10);
        check("lk_addr", sram_addr, idx);
        @(negedge clk);
        // Keep requests pending with different values while busy.
        lookup_tag = ~tag; lookup_id = ~id;
        write_valid = 1'b1; write_idx = IW'(idx); write_way = 2'd0; write_tag = tag; write_error = 1'b0;
        #1;
        check("rd_rsp_valid", rsp_valid, 1'b0);
        check("rd_busy", {lookup_ready, write_ready, flush_ready, sram_req}, 4'b0);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk); #1;
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_fields", {rsp_hit, rsp_way, rsp_error, rsp_id}, {eh, 2'(ew), ee, id});
            check("rsp_busy", {lookup_ready, write_ready, flush_ready, sram_req}, 4'b0);
            if (h == hold) begin
                lookup_valid = 1'b0; write_valid = 1'b0; rsp_ready = 1'b1;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("rsp_done", rsp_valid, 1'b0);
    endtask

    task automatic do_flush(input bit with_write);
        int lines;
        bit ok;
        @(negedge clk);
        flush_valid = 1'b1;
        if (with_write) begin
            write_valid = 1'b1; write_idx = 6'd5; write_way = 2'd0;
            write_tag = 20'h55555; write_error = 1'b0;
        end
        #1;
        check("fl_priority", {flush_ready, write_ready, lookup_ready, sram_req}, 4'b0);
        @(negedge clk);
        write_valid = 1'b0;
        sweep(-1, lines, ok);
        check("fl_lines", lines, LINES);
        check("fl_sweep_ok", ok, 1'b1);
        check("fl_ready", {flush_ready, write_ready, lookup_ready}, 3'b100);
        @(negedge clk);
        flush_valid = 1'b0;
        #1;
        check("fl_ready_pulse", flush_ready, 1'b0);
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lines;
        bit ok;
        int op, idx;
        logic [TW-1:0] tag;

        rst_n = 1'b0; scramble = 1'b1;
        flush_valid = 1'b0; lookup_valid = 1'b0; write_valid = 1'b0; rsp_ready = 1'b0;
        lookup_idx = '0; lookup_tag = '0; lookup_id = '0;
        write_idx = '0; write_way = '0; write_tag = '0; write_error = 1'b0;
        model_clear();

        // Reset and initial sweep.
        repeat (3) @(negedge clk);
        scramble = 1'b0;
        #1;
        check("rst_strobes", {sram_req, sram_write, rsp_valid, flush_ready, write_ready, lookup_ready}, 6'b0);
        check("rst_values", {sram_addr, sram_be, sram_wdata, rsp_hit, rsp_way, rsp_error, rsp_id}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(-1, lines, ok);
        check("init_lines", lines, LINES);
        check("init_sweep_ok", ok, 1'b1);
        check("init_ready", {lookup_ready, write_ready, flush_ready}, 3'b100);

        // Directed hit / miss / priority / backpressure.
        do_write(5, 2, 20'hABCDE, 1'b0);
        do_lookup(5, 20'hABCDE, 0);
        do_lookup(5, 20'hABCDF, 0);
        do_write(9, 1, 20'h12345, 1'b1);
        do_write(9, 3, 20'h12345, 1'b0);
        do_lookup(9, 20'h12345, 0);
        do_lookup(5, 20'hABCDE, 5);

        // Back-to-back writes on consecutive cycles.
        @(negedge clk);
        write_valid = 1'b1; write_idx = 6'd20; write_way = 2'd0; write_tag = 20'h00111; write_error = 1'b0;
        #1;
        check("b2b_first", {write_ready, sram_req, sram_addr}, {2'b11, 6'd20});
        @(negedge clk);
        write_idx = 6'd21; write_way = 2'd3; write_tag = 20'h00222; write_error = 1'b1;
        #1;
        check("b2b_second", {write_ready, sram_req, sram_addr, sram_be}, {2'b11, 6'd21, 4'b1000});
        @(negedge clk);
        write_valid = 1'b0;
        m_valid[20][0] = 1'b1; m_err[20][0] = 1'b0; m_tag[20][0] = 20'h00111;
        m_valid[21][3] = 1'b1; m_err[21][3] = 1'b1; m_tag[21][3] = 20'h00222;
        do_lookup(20, 20'h00111, 0);
        do_lookup(21, 20'h00222, 1);

        // Flush (write arriving together loses) then previous tags miss.
        do_flush(1'b1);
        do_lookup(5, 20'hABCDE, 0);
        do_lookup(9, 20'h12345, 0);

        // Randomized traffic on a small index/tag pool.
        for (int i = 0; i < 60; i++) begin
            op  = int'($urandom_range(0, 19));
            idx = int'($urandom_range(0, 3));
            tag = TW'(POOL + $urandom_range(0, 3));
            if (op == 0)
                do_flush(1'($urandom_range(0, 1)));
            else if (op < 9)
                do_write(idx, int'($urandom_range(0, 3)), tag, 1'($urandom_range(0, 1)));
            else
                do_lookup(idx, tag, int'($urandom_range(0, 3)));
        end

        // Reset while a response is pending discards it.
        do_write(2, 1, POOL, 1'b1);
        @(negedge clk);
        lookup_valid = 1'b1; lookup_idx = 6'd2; lookup_tag = POOL; lookup_id = 4'h9; rsp_ready = 1'b0;
        @(negedge clk);
        lookup_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_rsp", {rsp_valid, rsp_hit, rsp_way, rsp_error, rsp_id}, {1'b1, 1'b1, 2'd1, 1'b1, 4'h9});
        rst_n = 1'b0; scramble = 1'b1;
        #1;
        check("rst_rsp_drop", {rsp_valid, rsp_hit, rsp_way, rsp_error, rsp_id, sram_req}, '0);
        @(negedge clk);
        scramble = 1'b0; rst_n = 1'b1;
        model_clear();
        sweep(-1, lines, ok);
        check("reinit_lines", lines, LINES);
        check("reinit_sweep_ok", ok, 1'b1);
        do_lookup(2, POOL, 0);

        // Reset at flush sweep line 30 restarts a full init from line 0.
        do_write(3, 0, POOL + 20'd1, 1'b0);
        @(negedge clk);
        flush_valid = 1'b1;
        @(negedge clk);
        sweep(30, lines, ok);
        flush_valid = 1'b0; scramble = 1'b1;
        #1;
        check("abort_line", lines, 31);
        check("abort_outputs", {sram_req, sram_write, sram_be, flush_ready, write_ready, lookup_ready, rsp_valid}, '0);
        @(negedge clk);
        scramble = 1'b0; rst_n = 1'b1;
        model_clear();
        sweep(-1, lines, ok);
        check("restart_lines", lines, LINES);
        check("restart_sweep_ok", ok, 1'b1);
        check("restart_ready", lookup_ready, 1'b1);
        for (int i = 0; i < 4; i++) do_lookup(i, TW'(POOL + i), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
